pht_multi: RTL

PHT_MULTI -- requirements
Module: pht_multi

---
 rtl/pht_pkg.sv | 20 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pht_multi.sv | 107 ++++++++++
 3 files changed

// File: rtl/pht_pkg.sv
// Shared types and constants for the multi-port pattern history table.
package pht_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } pht_state_e;

   localparam int unsigned COUNTER_SIZE_DEF = 2;

   typedef logic [COUNTER_SIZE_DEF-1:0] counter_t;

   localparam counter_t COUNTER_MAX = '1;
   localparam counter_t COUNTER_MIN = '0;

   function automatic int unsigned counter_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational saturating up/down step for one branch-history counter.
module sat_counter #(
   parameter int unsigned COUNTER_SIZE = 2
) (
   input  logic [COUNTER_SIZE-1:0] current_i,
   input  logic                    taken_i,
   output logic [COUNTER_SIZE-1:0] next_o
);

   localparam logic [COUNTER_SIZE-1:0] CntMax = '1;
   localparam logic [COUNTER_SIZE-1:0] CntMin = '0;
   localparam logic [COUNTER_SIZE-1:0] CntOne = COUNTER_SIZE'(1);

   always_comb begin
      next_o = current_i;
      if (taken_i) begin
         if (current_i != CntMax) next_o = current_i + CntOne;
      end else begin
         if (current_i != CntMin) next_o = current_i - CntOne;
      end
   end

endmodule

// File: rtl/pht_multi.sv
// Multi-read-port PHT with an init sweep after reset and one commit-time update port.
// Define PHT_BYPASS_EN to forward a same-edge update to a matching read port.
module pht_multi
   import pht_pkg::*;
#(
   parameter int unsigned PHT_ADDRESS  = 9,
   parameter int unsigned COUNTER_SIZE = 2,
   parameter int unsigned NUM_READ     = 2,
   parameter int unsigned INIT_STATE   = 1
) (
   input  logic                            CLK,
   input  logic                            reset_n,
   input  logic [NUM_READ*PHT_ADDRESS-1:0] pht_index,
   input  logic                            update_pht,
   input  logic [PHT_ADDRESS-1:0]          rb_pht_index,
   input  logic                            actual_taken,
   output logic [NUM_READ-1:0]             pred_taken,
   output logic [NUM_READ-1:0]             pred_strong,
   output logic                            init_done
);

   localparam int unsigned Depth = 2 ** PHT_ADDRESS;
   localparam logic [PHT_ADDRESS-1:0]  LastIdx = '1;
   localparam logic [PHT_ADDRESS-1:0]  IdxOne  = PHT_ADDRESS'(1);
   localparam logic [COUNTER_SIZE-1:0] CntMax  = COUNTER_SIZE'(counter_max(COUNTER_SIZE));
   localparam logic [COUNTER_SIZE-1:0] InitVal = COUNTER_SIZE'(INIT_STATE);

   logic [COUNTER_SIZE-1:0] table_q [Depth];

   pht_state_e              state_q;
   logic [PHT_ADDRESS-1:0]  sweep_q;
   logic                    init_done_q;
   logic [NUM_READ-1:0]     pred_taken_q, pred_taken_d;
   logic [NUM_READ-1:0]     pred_strong_q, pred_strong_d;

   logic [COUNTER_SIZE-1:0] upd_next;
   logic                    upd_en;
   logic [PHT_ADDRESS-1:0]  rd_idx;
   logic [COUNTER_SIZE-1:0] rd_val;

   assign upd_en = update_pht && (state_q == READY);

   sat_counter #(
      .COUNTER_SIZE(COUNTER_SIZE)
   ) u_sat (
      .current_i(table_q[rb_pht_index]),
      .taken_i  (actual_taken),
      .next_o   (upd_next)
   );

   always_comb begin
      pred_taken_d  = '0;
      pred_strong_d = '0;
      rd_idx        = '0;
      rd_val        = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         rd_idx = pht_index[i*PHT_ADDRESS +: PHT_ADDRESS];
         rd_val = table_q[rd_idx];
`ifdef PHT_BYPASS_EN
         if (upd_en && (rd_idx == rb_pht_index)) rd_val = upd_next;
`endif
         pred_taken_d[i]  = rd_val[COUNTER_SIZE-1];
         pred_strong_d[i] = (rd_val == '0) || (rd_val == CntMax);
      end
   end

   // Table has no reset; the sweep rewrites every entry after reset_n rises.
   always_ff @(posedge CLK) begin
      if (state_q == INIT) begin
         table_q[sweep_q] <= InitVal;
      end else if (update_pht) begin
         table_q[rb_pht_index] <= upd_next;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= INIT;
         sweep_q       <= '0;
         init_done_q   <= 1'b0;
         pred_taken_q  <= '0;
         pred_strong_q <= '0;
      end else begin
         case (state_q)
            INIT: begin
               sweep_q       <= sweep_q + IdxOne;
               pred_taken_q  <= '0;
               pred_strong_q <= '0;
               if (sweep_q == LastIdx) begin
                  state_q     <= READY;
                  init_done_q <= 1'b1;
               end
            end
            READY: begin
               pred_taken_q  <= pred_taken_d;
               pred_strong_q <= pred_strong_d;
            end
            default: state_q <= INIT;
         endcase
      end
   end

   assign pred_taken  = pred_taken_q;
   assign pred_strong = pred_strong_q;
   assign init_done   = init_done_q;

endmodule
